matrix_output_collector: RTL and testbench

MATRIX_OUTPUT_COLLECTOR -- requirements
Module: matrix_output_collector

---
 rtl/matrix_output_pkg.sv | 23 ++
 rtl/collector_fifo.sv | 51 +++++
 rtl/matrix_output_collector.sv | 158 +++++++++++++++
 tb/tb_matrix_output_collector.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_output_pkg.sv
// Shared types for the matrix output collector: FIFO entry tag, arbiter states,
// drop counter width.
package matrix_output_pkg;

  localparam int DROP_COUNT_WIDTH = 16;

  // Marker part of a FIFO entry; the element data is appended by the collector.
  typedef struct packed {
    logic eom;
    logic end_row;
    logic data_valid;
  } entry_tag_t;

  typedef enum logic {
    ARB_IDLE,
    ARB_LOCKED
  } arb_state_t;

  function automatic logic closes_row(entry_tag_t tag);
    return tag.eom | tag.end_row;
  endfunction

endpackage

// File: rtl/collector_fifo.sv
// Per-channel FIFO: registered count, full/empty flags, one write and one read port.
// Read data is the head entry, available combinationally.
module collector_fifo #(
  parameter int WIDTH = 35,
  parameter int DEPTH = 8
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_wr, do_rd;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_wr   = wr_en_i & ~full_o;
  assign do_rd   = rd_en_i & ~empty_o;
  assign rd_data_o = mem_q[rd_ptr_q];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_rd) rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/matrix_output_collector.sv
// Merges per-channel matrix output streams into one row-atomic output stream.
// Optional feature: define OUTPUT_COLLECTOR_DROP_COUNT_EN for saturating drop counters.
module matrix_output_collector
  import matrix_output_pkg::*;
#(
  parameter int NUM_CHANNELS = 4,
  parameter int DATA_WIDTH   = 32,
  parameter int FIFO_DEPTH   = 8,
  localparam int CW          = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_CHANNELS-1:0]            in_en,
  input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_CHANNELS-1:0]            in_end_row,
  input  logic [NUM_CHANNELS-1:0]            in_end,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [DATA_WIDTH-1:0]              out_data,
  output logic                               out_data_valid,
  output logic                               out_end_row,
  output logic                               out_end,
  output logic [CW-1:0]                      out_channel,
  output logic [NUM_CHANNELS-1:0]            overflow,
  output logic [NUM_CHANNELS*DROP_COUNT_WIDTH-1:0] drop_count
);

  localparam int EW = DATA_WIDTH + 3;

  typedef struct packed {
    entry_tag_t            tag;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  entry_t                  wr_entry [NUM_CHANNELS];
  entry_t                  rd_entry [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] wr_req, fifo_full, fifo_empty, pop;

  for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
    assign wr_req[i] = in_en[i] | in_end_row[i] | in_end[i];
    assign wr_entry[i].tag.eom        = in_end[i];
    assign wr_entry[i].tag.end_row    = in_end_row[i];
    assign wr_entry[i].tag.data_valid = in_en[i];
    assign wr_entry[i].data = in_en[i] ? in_data[i*DATA_WIDTH +: DATA_WIDTH] : '0;

    collector_fifo #(
      .WIDTH(EW),
      .DEPTH(FIFO_DEPTH)
    ) u_fifo (
      .clk_i    (clk),
      .reset_i  (reset),
      .wr_en_i  (wr_req[i]),
      .wr_data_i(wr_entry[i]),
      .rd_en_i  (pop[i]),
      .rd_data_o(rd_entry[i]),
      .full_o   (fifo_full[i]),
      .empty_o  (fifo_empty[i])
    );
  end

  arb_state_t              state_q;
  logic [CW-1:0]           lock_q, rr_q;
  logic                    out_valid_q, out_data_valid_q, out_end_row_q, out_end_q;
  logic [DATA_WIDTH-1:0]   out_data_q;
  logic [CW-1:0]           out_channel_q;
  logic [NUM_CHANNELS-1:0] overflow_q;

  logic                    load, found;
  logic [CW-1:0]           grant;
  entry_t                  head;

  // Locked: only the locked channel may pop. Idle: round-robin after rr_q.
  always_comb begin
    int unsigned idx;
    load  = ~out_valid_q | out_ready;
    found = 1'b0;
    grant = lock_q;
    idx   = 0;
    if (state_q == ARB_LOCKED) begin
      found = ~fifo_empty[lock_q];
    end else begin
      grant = rr_q;
      for (int unsigned k = 1; k <= NUM_CHANNELS; k++) begin
        idx = (32'(rr_q) + k) % NUM_CHANNELS;
        if (!found && !fifo_empty[idx]) begin
          found = 1'b1;
          grant = CW'(idx);
        end
      end
    end
    pop = '0;
    if (load && found) pop[grant] = 1'b1;
    head = rd_entry[grant];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q          <= ARB_IDLE;
      lock_q           <= '0;
      rr_q             <= CW'(NUM_CHANNELS - 1);
      out_valid_q      <= 1'b0;
      out_data_q       <= '0;
      out_data_valid_q <= 1'b0;
      out_end_row_q    <= 1'b0;
      out_end_q        <= 1'b0;
      out_channel_q    <= '0;
      overflow_q       <= '0;
    end else begin
      overflow_q <= overflow_q | (wr_req & fifo_full);
      if (load) begin
        out_valid_q      <= found;
        out_data_q       <= found ? head.data : '0;
        out_data_valid_q <= found & head.tag.data_valid;
        out_end_row_q    <= found & head.tag.end_row;
        out_end_q        <= found & head.tag.eom;
        out_channel_q    <= found ? grant : '0;
        if (found) begin
          rr_q <= grant;
          if (closes_row(head.tag)) begin
            state_q <= ARB_IDLE;
          end else begin
            state_q <= ARB_LOCKED;
            lock_q  <= grant;
          end
        end
      end
    end
  end

  assign out_valid      = out_valid_q;
  assign out_data       = out_data_q;
  assign out_data_valid = out_data_valid_q;
  assign out_end_row    = out_end_row_q;
  assign out_end        = out_end_q;
  assign out_channel    = out_channel_q;
  assign overflow       = overflow_q;

`ifdef OUTPUT_COLLECTOR_DROP_COUNT_EN
  logic [NUM_CHANNELS*DROP_COUNT_WIDTH-1:0] drop_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_cnt_q <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
        if (wr_req[i] && fifo_full[i] && drop_cnt_q[i*DROP_COUNT_WIDTH +: DROP_COUNT_WIDTH] != '1)
          drop_cnt_q[i*DROP_COUNT_WIDTH +: DROP_COUNT_WIDTH] <=
            drop_cnt_q[i*DROP_COUNT_WIDTH +: DROP_COUNT_WIDTH] + DROP_COUNT_WIDTH'(1);
      end
    end
  end

  assign drop_count = drop_cnt_q;
`else
  assign drop_count = '0;
`endif

endmodule

// File: tb/tb_matrix_output_collector.sv
// Directed bench for matrix_output_collector (4 channels, 32-bit data, depth 8).
module tb_matrix_output_collector;

  localparam int N  = 4;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  in_en, in_end_row, in_end;
  logic [N*DW-1:0] in_data;
  logic          out_valid, out_ready, out_data_valid, out_end_row, out_end;
  logic [DW-1:0] out_data;
  logic [1:0]    out_channel;
  logic [N-1:0]  overflow;
  logic [N*16-1:0] drop_count;

  int n_cmp = 0;
  int n_bad = 0;

  matrix_output_collector #(
    .NUM_CHANNELS(N),
    .DATA_WIDTH  (DW),
    .FIFO_DEPTH  (8)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .in_en         (in_en),
    .in_data       (in_data),
    .in_end_row    (in_end_row),
    .in_end        (in_end),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_data_valid(out_data_valid),
    .out_end_row   (out_end_row),
    .out_end       (out_end),
    .out_channel   (out_channel),
    .overflow      (overflow),
    .drop_count    (drop_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    in_en = '0; in_end_row = '0; in_end = '0; in_data = '0;
  endtask

  task automatic put(input int ch, input bit en, input bit er, input bit e, input logic [DW-1:0] d);
    in_en[ch] = en; in_end_row[ch] = er; in_end[ch] = e;
    in_data[ch*DW +: DW] = d;
  endtask

  task automatic expect_out(input string tag, input bit v, input int ch, input bit dv,
                            input bit er, input bit e, input logic [DW-1:0] d);
    check({tag, ".valid"}, 64'(out_valid), 64'(v));
    check({tag, ".data"}, 64'(out_data), 64'(d));
    if (v) begin
      check({tag, ".chan"}, 64'(out_channel), 64'(ch));
      check({tag, ".dv"},   64'(out_data_valid), 64'(dv));
      check({tag, ".erow"}, 64'(out_end_row), 64'(er));
      check({tag, ".end"},  64'(out_end), 64'(e));
    end
  endtask

  initial begin
    logic [63:0] exp_drop;
    reset = 1'b1; out_ready = 1'b0; clr();
    tick(); tick();
    expect_out("rst.hold", 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    tick();
    expect_out("rst.rel", 0, 0, 0, 0, 0, 0);
    check("rst.ovf", 64'(overflow), 64'd0);
    check("rst.drop", drop_count, 64'd0);

    // ch0 row 5,6,end_row streamed with one cycle latency
    out_ready = 1'b1;
    clr(); put(0, 1, 0, 0, 5); tick();
    expect_out("t1.lat", 0, 0, 0, 0, 0, 0);
    clr(); put(0, 1, 0, 0, 6); tick();
    expect_out("t1.e5", 1, 0, 1, 0, 0, 5);
    clr(); put(0, 0, 1, 0, 0); tick();
    expect_out("t1.e6", 1, 0, 1, 0, 0, 6);
    clr(); tick();
    expect_out("t1.er", 1, 0, 0, 1, 0, 0);
    tick();
    expect_out("t1.idle", 0, 0, 0, 0, 0, 0);

    // ch1 and ch2 rows arrive together; ch1 row completes first
    clr(); put(1, 1, 0, 0, 10); put(2, 1, 0, 0, 20); tick();
    expect_out("t2.lat", 0, 0, 0, 0, 0, 0);
    clr(); put(1, 0, 1, 0, 0); put(2, 0, 1, 0, 0); tick();
    expect_out("t2.c1d", 1, 1, 1, 0, 0, 10);
    clr(); tick();
    expect_out("t2.c1r", 1, 1, 0, 1, 0, 0);
    tick();
    expect_out("t2.c2d", 1, 2, 1, 0, 0, 20);
    tick();
    expect_out("t2.c2r", 1, 2, 0, 1, 0, 0);
    tick();
    expect_out("t2.idle", 0, 0, 0, 0, 0, 0);
    // round-robin continues after ch2: ch3 before ch0
    clr(); put(0, 1, 1, 0, 1); put(3, 1, 0, 1, 3); tick();
    expect_out("t2.lat2", 0, 0, 0, 0, 0, 0);
    clr(); tick();
    expect_out("t2.rr3", 1, 3, 1, 0, 1, 3);
    tick();
    expect_out("t2.rr0", 1, 0, 1, 1, 0, 1);
    tick();
    expect_out("t2.idle2", 0, 0, 0, 0, 0, 0);

    // Overflow: output stalled on a ch1 entry, ch0 writes 9 elements
    out_ready = 1'b0;
    clr(); put(1, 1, 1, 0, 77); tick();
    clr(); tick();
    expect_out("t3.stall", 1, 1, 1, 1, 0, 77);
    for (int k = 0; k < 9; k++) begin
      clr(); put(0, 1, 0, 0, 32'(100 + k)); tick();
      if (k == 7) check("t3.ovf_pre", 64'(overflow), 64'd0);
    end
    clr();
    check("t3.ovf", 64'(overflow), 64'h1);
`ifdef OUTPUT_COLLECTOR_DROP_COUNT_EN
    exp_drop = 64'h1;
`else
    exp_drop = 64'h0;
`endif
    check("t3.drop", drop_count, exp_drop);
    expect_out("t3.held", 1, 1, 1, 1, 0, 77);
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      expect_out("t3.drain", 1, 0, 1, 0, 0, 32'(100 + k));
    end
    tick();
    expect_out("t3.empty", 0, 0, 0, 0, 0, 0);
    put(0, 0, 1, 0, 0); tick();
    expect_out("t3.erw", 0, 0, 0, 0, 0, 0);
    clr(); tick();
    expect_out("t3.er", 1, 0, 0, 1, 0, 0);
    tick();
    expect_out("t3.idle", 0, 0, 0, 0, 0, 0);

    // ch3 locked mid-row with empty FIFO blocks ch0
    clr(); put(3, 1, 0, 0, 30); tick();
    clr(); tick();
    expect_out("t4.c3", 1, 3, 1, 0, 0, 30);
    put(0, 1, 1, 0, 40); tick();
    expect_out("t4.blk0", 0, 0, 0, 0, 0, 0);
    clr(); tick();
    expect_out("t4.blk1", 0, 0, 0, 0, 0, 0);
    tick();
    expect_out("t4.blk2", 0, 0, 0, 0, 0, 0);
    put(3, 0, 1, 0, 0); tick();
    expect_out("t4.blk3", 0, 0, 0, 0, 0, 0);
    clr(); tick();
    expect_out("t4.c3r", 1, 3, 0, 1, 0, 0);
    tick();
    expect_out("t4.c0", 1, 0, 1, 1, 0, 40);
    tick();
    expect_out("t4.idle", 0, 0, 0, 0, 0, 0);

    // out_ready toggled 1,0,1 during a ch1 row
    clr(); put(1, 1, 0, 0, 50); tick();
    clr(); put(1, 1, 0, 0, 51); tick();
    expect_out("t5.e50", 1, 1, 1, 0, 0, 50);
    out_ready = 1'b0;
    clr(); put(1, 0, 1, 0, 0); tick();
    expect_out("t5.hold1", 1, 1, 1, 0, 0, 50);
    clr(); tick();
    expect_out("t5.hold2", 1, 1, 1, 0, 0, 50);
    out_ready = 1'b1; tick();
    expect_out("t5.e51", 1, 1, 1, 0, 0, 51);
    tick();
    expect_out("t5.er", 1, 1, 0, 1, 0, 0);
    tick();
    expect_out("t5.idle", 0, 0, 0, 0, 0, 0);

    // Reset mid-row with 3 entries buffered behind the output register
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      clr(); put(2, 1, 0, 0, 32'(60 + k)); tick();
    end
    clr();
    expect_out("t6.pre", 1, 2, 1, 0, 0, 60);
    #2 reset = 1'b1;
    #1;
    expect_out("t6.async", 0, 0, 0, 0, 0, 0);
    check("t6.ovf", 64'(overflow), 64'd0);
    check("t6.drop", drop_count, 64'd0);
    tick();
    reset = 1'b0; out_ready = 1'b1;
    tick();
    expect_out("t6.stale1", 0, 0, 0, 0, 0, 0);
    tick();
    expect_out("t6.stale2", 0, 0, 0, 0, 0, 0);
    put(0, 1, 1, 0, 7); put(3, 1, 1, 0, 8); tick();
    expect_out("t6.lat", 0, 0, 0, 0, 0, 0);
    clr(); tick();
    expect_out("t6.g0", 1, 0, 1, 1, 0, 7);
    tick();
    expect_out("t6.g3", 1, 3, 1, 1, 0, 8);
    tick();
    expect_out("t6.idle", 0, 0, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
